// File: rtl/core_pkg.sv
// Shared loader/dumper framing constants and block-size helpers.
// Both the UART loader and bmem_dumper import this so the byte framing cannot diverge.
package core_pkg;

    localparam logic [1:0] OP_INVALID = 2'b00;
    localparam logic [1:0] OP_IMEM    = 2'b01;
    localparam logic [1:0] OP_BMEM    = 2'b10;
    localparam logic [1:0] OP_UPDATE  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_LOCK    = 3'd3,
        ST_HEADER  = 3'd4,
        ST_ADDR    = 3'd5,
        ST_DATA    = 3'd6,
        ST_DONE    = 3'd7
    } dump_state_t;

    function automatic int f_nwords(input int mesh, input int tile);
        return mesh * mesh * tile * tile;
    endfunction

    function automatic int f_wbytes(input int bitwidth);
        return bitwidth / 8;
    endfunction

    function automatic int f_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bmem_dumper_serializer.sv
// Holds a captured BMEM block and presents one byte of it per index,
// word 0 first and each word LSB byte first, advancing on each accepted byte.
module word_byte_serializer #(
    parameter int BITWIDTH = 32,
    parameter int NWORDS   = 4,
    parameter int CW       = 5
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_capture,
    input  logic [BITWIDTH*NWORDS-1:0] i_block,
    input  logic                       i_clear,
    input  logic                       i_step,
    output logic [CW-1:0]              o_idx,
    output logic [7:0]                 o_byte
);

    logic [BITWIDTH*NWORDS-1:0] r_buf;
    logic [CW-1:0]              r_idx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_buf <= '0;
            r_idx <= '0;
        end else begin
            if (i_capture) r_buf <= i_block;
            if (i_clear) begin
                r_idx <= '0;
            end else if (i_step) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Flat byte index maps straight onto the packed block because words are little-endian packed.
    assign o_byte = 8'(r_buf >> {r_idx, 3'b000});
    assign o_idx  = r_idx;

endmodule

// File: rtl/bmem_dumper.sv
// Dumps one BMEM block over the UART write-lock slot using the loader framing:
// header byte, address bytes (LSB first), then block data bytes.
module bmem_dumper
    import core_pkg::*;
#(
    parameter int BITWIDTH  = 32,
    parameter int MESHUNITS = 2,
    parameter int TILEUNITS = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                dump_req,
    input  logic [BITWIDTH-1:0] dump_addr,
    output logic                dump_busy,
    output logic                dump_done,
    output logic [BITWIDTH-1:0] bmem_read_addr,
    input  logic [BITWIDTH*MESHUNITS*MESHUNITS*TILEUNITS*TILEUNITS-1:0] bmem_read_data,
    output logic                write_lock_req,
    input  logic                write_lock_res,
    input  logic                write_ready,
    output logic [7:0]          write_data,
    output logic                write_data_valid,
    output logic [2:0]          dbg_state
);

    localparam int NWORDS = f_nwords(MESHUNITS, TILEUNITS);
    localparam int WBYTES = f_wbytes(BITWIDTH);
    localparam int NDATA  = NWORDS * WBYTES;
    localparam int CW     = f_clog2(NDATA + 1);
    localparam logic [CW-1:0] ADDR_LAST = CW'(WBYTES - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(NDATA - 1);
    localparam logic [7:0]    HEADER_BYTE = {OP_BMEM, 6'b000000};

    dump_state_t         r_state;
    dump_state_t         w_next;
    logic [BITWIDTH-1:0] r_addr;
    logic                w_fire;
    logic                w_clear;
    logic                w_step;
    logic [CW-1:0]       w_idx;
    logic [7:0]          w_data_byte;
    logic [7:0]          w_addr_byte;

    // A byte moves only when valid, ready and the grant coincide.
    assign w_fire  = write_data_valid && write_ready && write_lock_res;
    assign w_clear = w_fire && ((r_state == ST_HEADER) ||
                                ((r_state == ST_ADDR) && (w_idx == ADDR_LAST)));
    assign w_step  = w_fire && ((r_state == ST_ADDR) || (r_state == ST_DATA));

    assign w_addr_byte    = 8'(r_addr >> {w_idx, 3'b000});
    assign bmem_read_addr = r_addr;
    assign dbg_state      = r_state;

    word_byte_serializer #(
        .BITWIDTH (BITWIDTH),
        .NWORDS   (NWORDS),
        .CW       (CW)
    ) u_ser (
        .i_clk     (clock),
        .i_rst     (reset),
        .i_capture (r_state == ST_CAPTURE),
        .i_block   (bmem_read_data),
        .i_clear   (w_clear),
        .i_step    (w_step),
        .o_idx     (w_idx),
        .o_byte    (w_data_byte)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == ST_IDLE) && dump_req) r_addr <= dump_addr;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (dump_req) w_next = ST_READ;
            ST_READ:    w_next = ST_CAPTURE;
            ST_CAPTURE: w_next = ST_LOCK;
            ST_LOCK:    if (write_lock_res) w_next = ST_HEADER;
            ST_HEADER:  if (w_fire) w_next = ST_ADDR;
            ST_ADDR:    if (w_fire && (w_idx == ADDR_LAST)) w_next = ST_DATA;
            ST_DATA:    if (w_fire && (w_idx == DATA_LAST)) w_next = ST_DONE;
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Valid follows the grant so a lost lock stalls the pending byte without consuming it.
    always_comb begin
        dump_busy        = 1'b0;
        dump_done        = 1'b0;
        write_lock_req   = 1'b0;
        write_data_valid = 1'b0;
        write_data       = 8'h00;
        case (r_state)
            ST_READ, ST_CAPTURE: dump_busy = 1'b1;
            ST_LOCK: begin
                dump_busy      = 1'b1;
                write_lock_req = 1'b1;
            end
            ST_HEADER: begin
                dump_busy        = 1'b1;
                write_lock_req   = 1'b1;
                write_data_valid = write_lock_res;
                write_data       = HEADER_BYTE;
            end
            ST_ADDR: begin
                dump_busy        = 1'b1;
                write_lock_req   = 1'b1;
                write_data_valid = write_lock_res;
                write_data       = w_addr_byte;
            end
            ST_DATA: begin
                dump_busy        = 1'b1;
                write_lock_req   = 1'b1;
                write_data_valid = write_lock_res;
                write_data       = w_data_byte;
            end
            ST_DONE: dump_done = 1'b1;
            default: dump_busy = 1'b0;
        endcase
    end

endmodule
